// File: rtl/shift_pkg.sv
// Shared definitions for the iterative shifter.
// Holds the opcode encodings used by the control unit and the FSM state
// encoding of serial_shifter.
package shift_pkg;

  localparam logic [1:0] OP_SLL  = 2'b00;
  localparam logic [1:0] OP_SRL  = 2'b01;
  localparam logic [1:0] OP_ROTL = 2'b10;
  localparam logic [1:0] OP_SRA  = 2'b11;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

endpackage

// File: rtl/shift_step.sv
// Single one-bit shift step, purely combinational.
// Ports:
//   w      - current working value
//   op     - operation select (OP_SLL / OP_SRL / OP_SRA / OP_ROTL)
//   w_next - value after exactly one bit position of the selected shift
module shift_step
  import shift_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] w,
  input  logic [1:0]       op,
  output logic [WIDTH-1:0] w_next
);

  always_comb begin
    w_next = w;
    case (op)
      OP_SLL:  w_next = {w[WIDTH-2:0], 1'b0};
      OP_SRL:  w_next = {1'b0, w[WIDTH-1:1]};
      // sign bit re-injected every step so negative operands stay negative
      OP_SRA:  w_next = {w[WIDTH-1], w[WIDTH-1:1]};
      OP_ROTL: w_next = {w[WIDTH-2:0], w[WIDTH-1]};
      default: w_next = w;
    endcase
  end

endmodule

// File: rtl/serial_shifter.sv
// Multi-cycle iterative shifter (SLL/SRL/SRA/ROTL), one bit per clock.
// Ports:
//   clk    - system clock, rising edge
//   reset  - synchronous active-high reset
//   start  - request; accepted only in IDLE or DONE
//   op     - operation select (see shift_pkg)
//   data   - operand, captured on accept
//   shamt  - shift amount, captured on accept
//   busy   - high while shifting
//   done   - one-cycle pulse, result valid
//   result - shifted value, held until the next completed operation
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for start
// SHIFT | stepping working register; count holds remaining steps
// DONE  | result just loaded, done pulse; start here is accepted
module serial_shifter
  import shift_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] data,
  input  logic [SHW-1:0]   shamt,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  logic [1:0]       state;
  logic [1:0]       op_q;
  logic [SHW-1:0]   count;
  logic [WIDTH-1:0] w;
  logic [WIDTH-1:0] w_next;
  logic             ready;

  shift_step #(.WIDTH(WIDTH)) u_step (
    .w      (w),
    .op     (op_q),
    .w_next (w_next)
  );

  assign ready = (state == IDLE) || (state == DONE);
  assign busy  = (state == SHIFT);
  assign done  = (state == DONE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      op_q   <= OP_SLL;
      count  <= '0;
      w      <= '0;
      result <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (ready && start) begin
            w     <= data;
            op_q  <= op;
            count <= shamt;
            state <= SHIFT;
          end else begin
            state <= IDLE;
          end
        end
        SHIFT: begin
          // one extra cycle with count==0 hands w over to result, so the
          // latency is always shamt+2 from the start cycle
          if (count != '0) begin
            w     <= w_next;
            count <= count - SHW'(1);
          end else begin
            result <= w;
            state  <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_shifter.sv
module tb_serial_shifter;
  import shift_pkg::*;

  localparam int WIDTH = 32;
  localparam int SHW   = 5;

  logic             clk;
  logic             reset;
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] data;
  logic [SHW-1:0]   shamt;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;

  int vectors;
  int miscompares;
  int cyc;
  int busy_n;
  int overlap_n;
  int done_seen;

  serial_shifter #(.WIDTH(WIDTH)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .op     (op),
    .data   (data),
    .shamt  (shamt),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // advance one clock; inputs and outputs are handled 1ns after the edge
  task automatic tick();
    if (busy) busy_n++;
    if (busy && done) overlap_n++;
    if (done) done_seen++;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic issue(input logic [1:0] o, input logic [31:0] d, input int s);
    start = 1'b1;
    op    = o;
    data  = d;
    shamt = SHW'(s);
    cyc   = 0;
    busy_n = 0;
    tick();
    start = 1'b0;
    data  = 32'h5A5A_A5A5;
    shamt = SHW'(7);
    op    = OP_ROTL;
  endtask

  task automatic finish_op(input string tag, input logic [31:0] exp, input int s);
    while (!done && cyc < 200) tick();
    chk({tag, "_latency"}, cyc, s + 2);
    chk({tag, "_result"}, result, exp);
    chk({tag, "_busycycles"}, busy_n, s + 1);
    chk({tag, "_busy_at_done"}, {31'b0, busy}, 32'h0);
  endtask

  initial begin
    vectors = 0; miscompares = 0; cyc = 0; busy_n = 0; overlap_n = 0; done_seen = 0;
    reset = 1'b1; start = 1'b0; op = OP_SLL; data = '0; shamt = '0;
    @(posedge clk); #1;
    @(posedge clk); #1;

    chk("reset_busy", {31'b0, busy}, 32'h0);
    chk("reset_done", {31'b0, done}, 32'h0);
    chk("reset_result", result, 32'h0);

    // reset wins over a simultaneous start
    start = 1'b1; op = OP_SLL; data = 32'h1; shamt = 5'd1;
    tick();
    chk("reset_vs_start_busy", {31'b0, busy}, 32'h0);
    start = 1'b0; reset = 1'b0;
    tick();
    chk("idle_busy", {31'b0, busy}, 32'h0);

    issue(OP_SRA, 32'h8000_0000, 4);
    chk("sra_result_held_shifting", result, 32'h0);
    finish_op("sra4", 32'hF800_0000, 4);
    tick();
    chk("sra4_done_pulse_width", {31'b0, done}, 32'h0);
    chk("sra4_result_held_idle", result, 32'hF800_0000);

    issue(OP_SRL, 32'h8000_0000, 4);
    finish_op("srl4", 32'h0800_0000, 4);
    tick();

    issue(OP_SLL, 32'h0000_0001, 31);
    finish_op("sll31", 32'h8000_0000, 31);
    tick();

    issue(OP_ROTL, 32'h8000_0001, 1);
    finish_op("rotl1", 32'h0000_0003, 1);
    tick();

    issue(OP_ROTL, 32'h1234_5678, 31);
    finish_op("rotl31", 32'h091A_2B3C, 31);
    tick();

    issue(OP_SRA, 32'h7000_0000, 3);
    finish_op("sra_pos3", 32'h0E00_0000, 3);
    tick();

    // shamt=0 then back-to-back start in the DONE cycle
    issue(OP_SRA, 32'hDEAD_BEEF, 0);
    finish_op("sra0", 32'hDEAD_BEEF, 0);
    issue(OP_SLL, 32'h0000_0001, 2);
    chk("b2b_done_one_cycle", {31'b0, done}, 32'h0);
    chk("b2b_busy", {31'b0, busy}, 32'h1);
    chk("b2b_result_held", result, 32'hDEAD_BEEF);
    finish_op("b2b_sll2", 32'h0000_0004, 2);
    tick();
    chk("b2b_done_pulse_width", {31'b0, done}, 32'h0);

    // start during SHIFT is ignored
    issue(OP_SRL, 32'h8000_0000, 4);
    tick();
    start = 1'b1; op = OP_SLL; data = 32'hFFFF_FFFF; shamt = 5'd1;
    tick();
    start = 1'b0;
    finish_op("ignore_start", 32'h0800_0000, 4);
    tick();

    // reset mid-operation aborts without a done pulse
    issue(OP_SLL, 32'h0000_0001, 10);
    tick(); tick(); tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("abort_busy", {31'b0, busy}, 32'h0);
    chk("abort_done", {31'b0, done}, 32'h0);
    chk("abort_result", result, 32'h0);
    done_seen = 0;
    for (int i = 0; i < 16; i++) tick();
    chk("abort_no_done", done_seen, 0);

    chk("busy_done_overlap", overlap_n, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
